// File: rtl/nv_nvdla_rt_csb_pkg.sv
// Shared constants and the parity helper for the CSB retiming pipe.
// Parity bit width depends on NVDLA_RT_CSB_PIPE_PARITY_EN.
package nv_nvdla_rt_csb_pkg;

    localparam int CSB_REQ_W    = 63;
    localparam int CSB_RESP_W   = 34;
    localparam int RT_MAX_DEPTH = 8;

    // Widest payload the parity helper accepts; callers zero-extend, which leaves parity unchanged.
    localparam int RT_PAR_MAX_W = 512;

`ifdef NVDLA_RT_CSB_PIPE_PARITY_EN
    localparam int RT_PAR_W = 1;
`else
    localparam int RT_PAR_W = 0;
`endif

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic rt_even_parity(input logic [RT_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/nv_nvdla_rt_pipe_stage.sv
// One valid/payload register slice; 1 cycle latency.
// BP=1: accepts when empty or when downstream takes the held entry; BP=0: always accepts.
module nv_nvdla_rt_pipe_stage #(
    parameter int W  = 63,
    parameter bit BP = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;
    logic         load;

    always_comb begin
        load  = BP ? (!vld_q || out_rdy_i) : 1'b1;
        vld_d = vld_q;
        dat_d = dat_q;
        if (load) begin
            vld_d = in_vld_i;
            // Payload only moves with a real request so idle cycles keep the last value.
            if (in_vld_i) begin
                dat_d = in_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign in_rdy_o  = load;
    assign out_vld_o = vld_q;
    assign out_dat_o = dat_q;

endmodule

// File: rtl/nv_nvdla_rt_csb_pipe.sv
// CSB retiming pipe: REQ_DEPTH request slices (optional valid/ready), RESP_DEPTH valid-only response delay.
// NVDLA_RT_CSB_PIPE_PARITY_EN adds per-stage request parity and a sticky req_parity_err output.
module nv_nvdla_rt_csb_pipe
    import nv_nvdla_rt_csb_pkg::*;
#(
    parameter int REQ_W      = CSB_REQ_W,
    parameter int RESP_W     = CSB_RESP_W,
    parameter int REQ_DEPTH  = 3,
    parameter int RESP_DEPTH = 3,
    parameter bit REQ_BP     = 1'b0
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              req_src_pvld,
    output logic              req_src_prdy,
    input  logic [REQ_W-1:0]  req_src_pd,
    output logic              req_dst_pvld,
    input  logic              req_dst_prdy,
    output logic [REQ_W-1:0]  req_dst_pd,
    input  logic              resp_src_valid,
    input  logic [RESP_W-1:0] resp_src_pd,
    output logic              resp_dst_valid,
    output logic [RESP_W-1:0] resp_dst_pd,
    output logic              req_pipe_busy
`ifdef NVDLA_RT_CSB_PIPE_PARITY_EN
    ,
    output logic              req_parity_err
`endif
);

    localparam int RQ_W = REQ_W + RT_PAR_W;

    // Index 0 is the source side; index DEPTH is the destination side.
    logic            req_vld [REQ_DEPTH+1];
    logic            req_rdy [REQ_DEPTH+1];
    logic [RQ_W-1:0] req_dat [REQ_DEPTH+1];

    logic              resp_vld [RESP_DEPTH+1];
    logic              resp_rdy [RESP_DEPTH+1];
    logic [RESP_W-1:0] resp_dat [RESP_DEPTH+1];

    logic unused_dst_prdy;
    logic unused_resp_rdy;

    assign req_vld[0] = req_src_pvld;
    assign req_src_prdy = req_rdy[0];
    // Legacy mode never stalls, so the sub-unit ready is not part of the chain.
    assign req_rdy[REQ_DEPTH] = REQ_BP ? req_dst_prdy : 1'b1;
    assign unused_dst_prdy = req_dst_prdy;

    for (genvar i = 0; i < REQ_DEPTH; i++) begin : g_req
        nv_nvdla_rt_pipe_stage #(
            .W  (RQ_W),
            .BP (REQ_BP)
        ) u_stage (
            .clk_i     (nvdla_core_clk),
            .rst_i     (nvdla_core_rst),
            .in_vld_i  (req_vld[i]),
            .in_rdy_o  (req_rdy[i]),
            .in_dat_i  (req_dat[i]),
            .out_vld_o (req_vld[i+1]),
            .out_rdy_i (req_rdy[i+1]),
            .out_dat_o (req_dat[i+1])
        );
    end

    assign req_dst_pvld = req_vld[REQ_DEPTH];
    assign req_dst_pd   = req_dat[REQ_DEPTH][REQ_W-1:0];

    always_comb begin
        req_pipe_busy = 1'b0;
        for (int i = 1; i <= REQ_DEPTH; i++) begin
            req_pipe_busy = req_pipe_busy | req_vld[i];
        end
    end

`ifdef NVDLA_RT_CSB_PIPE_PARITY_EN
    logic par_err_q, par_err_d;
    logic dst_par;

    assign req_dat[0] = {rt_even_parity(RT_PAR_MAX_W'(req_src_pd)), req_src_pd};
    assign dst_par    = req_dat[REQ_DEPTH][REQ_W];

    always_comb begin
        par_err_d = par_err_q;
        if (req_dst_pvld && (dst_par != rt_even_parity(RT_PAR_MAX_W'(req_dst_pd)))) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign req_parity_err = par_err_q;
`else
    assign req_dat[0] = req_src_pd;
`endif

    // Response path: fixed delay line, the CSB master always sinks responses.
    assign resp_vld[0]          = resp_src_valid;
    assign resp_dat[0]          = resp_src_pd;
    assign resp_rdy[RESP_DEPTH] = 1'b1;
    assign unused_resp_rdy      = resp_rdy[0];

    for (genvar i = 0; i < RESP_DEPTH; i++) begin : g_resp
        nv_nvdla_rt_pipe_stage #(
            .W  (RESP_W),
            .BP (1'b0)
        ) u_stage (
            .clk_i     (nvdla_core_clk),
            .rst_i     (nvdla_core_rst),
            .in_vld_i  (resp_vld[i]),
            .in_rdy_o  (resp_rdy[i]),
            .in_dat_i  (resp_dat[i]),
            .out_vld_o (resp_vld[i+1]),
            .out_rdy_i (resp_rdy[i+1]),
            .out_dat_o (resp_dat[i+1])
        );
    end

    assign resp_dst_valid = resp_vld[RESP_DEPTH];
    assign resp_dst_pd    = resp_dat[RESP_DEPTH];

endmodule

// File: doc/nv_nvdla_rt_csb_pipe.md
Name: nv_nvdla_rt_csb_pipe

Overview:
- Parametrised CSB retiming pipe between the CSB master and one NVDLA sub-unit; successor of the fixed 3-stage, fixed-width CSB retiming blocks.
- Request path: REQ_DEPTH register slices with optional real valid/ready backpressure.
- Response path: RESP_DEPTH-cycle valid-only delay line.
- One instance serves any sub-unit (cmac, cdma, sdp, ...) by setting widths and depths.

Parameters:
- REQ_W, 63, request payload width (bits).
- RESP_W, 34, response payload width (bits).
- REQ_DEPTH, 3, number of request register stages (0..8; 0 = combinational pass-through).
- RESP_DEPTH, 3, number of response delay stages (0..8; 0 = pass-through).
- REQ_BP, 0, 0 = legacy mode (no backpressure); 1 = ready/valid backpressure through every request stage.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rst  in  1  synchronous reset, active-high.
- req_src_pvld  in  1  request valid from the CSB master.
- req_src_prdy  out  1  request ready to the CSB master.
- req_src_pd  in  REQ_W  request payload.
- req_dst_pvld  out  1  request valid to the sub-unit.
- req_dst_prdy  in  1  request ready from the sub-unit (ignored when REQ_BP=0).
- req_dst_pd  out  REQ_W  request payload to the sub-unit.
- resp_src_valid  in  1  response valid from the sub-unit.
- resp_src_pd  in  RESP_W  response payload.
- resp_dst_valid  out  1  response valid to the CSB master.
- resp_dst_pd  out  RESP_W  response payload to the CSB master.
- req_pipe_busy  out  1  OR of all request-stage valid bits.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset values: all stage valid bits 0, all payload registers 0. Outputs during and after reset: req_dst_pvld=0, resp_dst_valid=0, req_dst_pd=0, resp_dst_pd=0, req_pipe_busy=0.
- req_src_prdy=1 while in reset when REQ_BP=0; req_src_prdy=1 when REQ_BP=1 because all stages are empty.
- Reset asserted mid-operation drops all in-flight requests and responses; no partial output after reset.
- REQ_BP=0 request path:
  - req_src_prdy tied 1.
  - valid shifts one stage per cycle.
  - payload register loads only when the incoming valid is 1, otherwise holds.
  - latency exactly REQ_DEPTH cycles.
  - req_dst_prdy is ignored; the sub-unit must always accept.
- REQ_BP=1 request path, stage i with valid v_i:
  - ready_in_i = !v_i || ready_out_i; ready_out of the last stage = req_dst_prdy; req_src_prdy = ready_in_0.
  - The ready chain is combinational across stages, with no extra ready register.
  - Stage loads when ready_in_i is 1. New valid equals the upstream valid; payload updates only when the upstream valid is 1.
  - Throughput: 1 request/cycle when unstalled; latency REQ_DEPTH cycles.
  - Bubbles collapse: an empty stage accepts even while downstream stalls.
  - Full pipe with req_dst_prdy=0 deasserts req_src_prdy in the same cycle. Payloads are held stable, with no drop or duplication.
  - Simultaneous pop at the output and push at the input of a full pipe: both happen in the same cycle and occupancy is unchanged.
- REQ_DEPTH=0: req_dst_* = req_src_* combinationally; req_src_prdy = REQ_BP ? req_dst_prdy : 1; req_pipe_busy=0.
- Response path:
  - valid-only shift line, no backpressure.
  - payload loads only when valid; latency exactly RESP_DEPTH cycles.
  - Back-to-back responses are preserved.
- Payload width: full REQ_W/RESP_W, no truncation. No X assignment in any branch.

Optional Feature:
- Macro NVDLA_RT_CSB_PIPE_PARITY_EN.
- Defined:
  - Each request stage carries one extra even-parity bit, generated from req_src_pd at entry and propagated alongside the payload.
  - At the output, parity is recomputed and compared when req_dst_pvld=1.
  - A mismatch sets a sticky output port req_parity_err (1 bit, reset 0, cleared only by nvdla_core_rst).
- Undefined: the port and the parity bits are absent; behaviour is otherwise identical.

Decomposition:
- Package nv_nvdla_rt_csb_pkg:
  - default width constants CSB_REQ_W=63 and CSB_RESP_W=34;
  - max depth constant RT_MAX_DEPTH=8;
  - parity function.
- Sub-module nv_nvdla_rt_pipe_stage: one valid/payload slice with a BP parameter. It is instantiated by generate REQ_DEPTH times on the request path and RESP_DEPTH times (BP=0) on the response path.

Test Plan:
- Default params, single request pd=63'h1234 at cycle 10 -> req_dst_pvld=1 with pd=63'h1234 at cycle 13 only; req_src_prdy constant 1.
- Response burst of 4 back-to-back valids (pd 1,2,3,4) -> resp_dst_valid high cycles +3..+6 with pd 1,2,3,4 in order.
- REQ_BP=1, REQ_DEPTH=3, req_dst_prdy=0, stream requests 1..5 -> exactly 3 accepted, req_src_prdy=0 from the 4th. Release prdy -> outputs 1,2,3,4,5 in order, no loss or duplicates, 1/cycle.
- REQ_BP=1, random req_dst_prdy toggling over 1000 transactions -> scoreboard matches in order; payload stable while req_dst_pvld=1 and req_dst_prdy=0.
- Reset asserted with 2 requests and 1 response in flight -> all valids 0 the next cycle, and nothing emitted afterwards.
- REQ_DEPTH=0 and RESP_DEPTH=0 -> same-cycle pass-through. With NVDLA_RT_CSB_PIPE_PARITY_EN, a forced bit flip in stage 1 -> req_parity_err=1 and sticky until reset.
